seg_digit_counter: RTL
======================

# seg_digit_counter

Two-digit BCD up/down counter that produces the packed seven-segment patterns consumed by the display multiplexer stage. Each output word holds the tens pattern in [13:7] and the ones pattern in [6:0], which is the `both7seg` format the multiplexer expects. An internal prescaler paces counting. Load, direction and enable controls let the surrounding design use the block as a timer, scoreboard or event counter.

## Interface
- `TICK_DIV`, 2500: prescaler period in clk cycles. One count step per period. Legal range is 1..4095.
- `CBITS`, 12: width of the prescaler counter. Must satisfy 2^CBITS ≥ TICK_DIV.
- `BLANK_LZ`, 0: when 1, the tens pattern is blanked (7'h00) whenever the tens digit is 0.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  count enable. While low, the prescaler and the digits hold.
- `up`  input  1  direction: 1 = increment, 0 = decrement. Sampled on tick cycles.
- `load`  input  1  synchronous load strobe for `load_val`.
- `load_val`  input  8  BCD value to load: [7:4] tens, [3:0] ones.
- `bcd`  output  8  current count in BCD: [7:4] tens, [3:0] ones.
- `both7seg`  output  14  packed segment patterns: [13:7] tens, [6:0] ones.
- `wrap`  output  1  one-cycle pulse on rollover 99→00 or underflow 00→99.

## Operation
- Segment encoding: bit order g,f,e,d,c,b,a from MSB to LSB, active-high.
  - Digits 0..9: 7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F.
- Prescaler `cnt` (CBITS bits):
  - With `en`=1 it counts 0..TICK_DIV-1 and then returns to 0.
  - The tick cycle is the cycle in which `cnt`==TICK_DIV-1 and `en`=1.
  - With TICK_DIV=1, every enabled cycle is a tick.
- On a tick, with `up`=1:
  - Ones increments.
  - Ones 9→0 carries into tens.
  - 99→00 asserts `wrap`.
- On a tick, with `up`=0:
  - Ones decrements.
  - Ones 0→9 borrows from tens.
  - 00→99 asserts `wrap`.
- `load`=1 has priority over a tick in the same cycle:
  - `bcd` ← `load_val`.
  - `cnt` ← 0.
  - `wrap` = 0 in that cycle.
  - `load` acts regardless of `en`.
- Invalid load: if either nibble of `load_val` exceeds 9, the entire load is ignored. State and prescaler behave as if `load`=0.
- `both7seg` is always the decode of the current `bcd`, registered in the same cycle as `bcd`.
  - Tens pattern is 7'h00 when BLANK_LZ=1 and tens==0.
  - The ones digit is never blanked.
- `bcd` digits never leave 0..9.

## Timing
- Reset (asynchronous assert, outputs valid immediately):
  - `cnt`=0.
  - `bcd`=8'h00.
  - `wrap`=0.
  - `both7seg`=14'h1FBF when BLANK_LZ=0, or 14'h003F when BLANK_LZ=1.
- Reset dominates `load` and `en`.
- Release is synchronous in effect: the first prescaler increment happens on the first rising edge with `rst`=0 and `en`=1.
- Latency:
  - `bcd` and `both7seg` update on the clock edge that ends the tick or load cycle.
  - `wrap` is registered and high for exactly the cycle following that edge, aligned with the new `bcd`.
- From reset release with `en` held high, the first count step lands TICK_DIV edges after release. Later steps occur every TICK_DIV cycles.
- Deasserting `en` mid-period freezes `cnt`. Reasserting it resumes from the frozen value; the period is not restarted.
- Changing `up` between ticks has no effect until the next tick.
- Reset asserted mid-period clears all state at once. No pending tick survives.

## Test plan
- Reset and decode (TICK_DIV=4, BLANK_LZ=0):
  - During reset: `bcd`=8'h00, `both7seg`=14'h1FBF, `wrap`=0.
  - Release with `en`=1: `bcd`=8'h01 and `both7seg`=14'h1F86 after 4 edges, and 8'h02 after 8 edges.
- Up rollover: load 8'h98, then `en`=1, `up`=1.
  - Next tick gives 8'h99.
  - Following tick gives 8'h00 with `wrap` high for exactly 1 cycle.
- Down underflow: load 8'h10, `up`=0.
  - Ticks give 8'h09 and then 8'h00.
  - Next tick gives 8'h99 with a 1-cycle `wrap` pulse.
- Load priority and validity:
  - `load` asserted on a tick cycle with `load_val`=8'h42: `bcd`=8'h42, no step, `cnt`=0.
  - `load_val`=8'h3A: ignored, state unchanged.
- Enable freeze: drop `en` after 2 of 4 prescaler cycles for 10 cycles, then restore.
  - The next step occurs exactly 2 enabled cycles later.
- Blanking and mid-operation reset (BLANK_LZ=1):
  - `bcd`=8'h07 gives `both7seg`=14'h0007.
  - Assert `rst` asynchronously between edges: outputs go immediately to 8'h00 and 14'h003F.

Source files
------------

// File: rtl/seg_digit_counter.sv
// Two-digit BCD up/down counter with prescaler, load and packed seven-segment output.
// both7seg carries the tens pattern in [13:7] and the ones pattern in [6:0].
module seg_digit_counter #(
  parameter int unsigned TICK_DIV = 2500,
  parameter int unsigned CBITS    = 12,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [7:0]  load_val,
  output logic [7:0]  bcd,
  output logic [13:0] both7seg,
  output logic        wrap
);

  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(TICK_DIV - 1);

  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_nxt_c;
  logic [7:0]       bcd_nxt_c;
  logic             wrap_nxt_c;
  logic             tick_c;
  logic             load_ok_c;
  logic [3:0]       tens_c;
  logic [3:0]       ones_c;

  // Active-high segments, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] seg_word(input logic [7:0] v);
    logic [6:0] tens_seg;
    tens_seg = (BLANK_LZ && (v[7:4] == 4'd0)) ? 7'h00 : seg7(v[7:4]);
    return {tens_seg, seg7(v[3:0])};
  endfunction

  // Next-state: a valid load beats a tick; an invalid load is as if absent.
  always_comb begin
    tens_c     = bcd[7:4];
    ones_c     = bcd[3:0];
    cnt_nxt_c  = cnt;
    bcd_nxt_c  = bcd;
    wrap_nxt_c = 1'b0;
    load_ok_c  = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    tick_c     = en && (cnt == CNT_LAST);

    if (load_ok_c) begin
      bcd_nxt_c = load_val;
      cnt_nxt_c = '0;
    end else if (en) begin
      cnt_nxt_c = tick_c ? '0 : cnt + CBITS'(1);
      if (tick_c) begin
        if (up) begin
          if (ones_c == 4'd9) begin
            ones_c = 4'd0;
            if (tens_c == 4'd9) begin
              tens_c     = 4'd0;
              wrap_nxt_c = 1'b1;
            end else begin
              tens_c = tens_c + 4'd1;
            end
          end else begin
            ones_c = ones_c + 4'd1;
          end
        end else begin
          if (ones_c == 4'd0) begin
            ones_c = 4'd9;
            if (tens_c == 4'd0) begin
              tens_c     = 4'd9;
              wrap_nxt_c = 1'b1;
            end else begin
              tens_c = tens_c - 4'd1;
            end
          end else begin
            ones_c = ones_c - 4'd1;
          end
        end
        bcd_nxt_c = {tens_c, ones_c};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bcd      <= 8'h00;
      both7seg <= seg_word(8'h00);
      wrap     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt_c;
      bcd      <= bcd_nxt_c;
      both7seg <= seg_word(bcd_nxt_c);
      wrap     <= wrap_nxt_c;
    end
  end

endmodule
